// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronized input, oversampled bit timing with 2-of-3 majority
// voting, optional even/odd parity, and one-cycle result pulses after each stop bit.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BUSY
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_DEC  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;

  logic                  rx_s, maj, at_dec, at_wrap;
  logic [DATA_WIDTH:0]   shift_ext;

  assign rx_s      = sync2_q;
  assign maj       = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign at_dec    = (tick_q == TICK_DEC);
  assign at_wrap   = (tick_q == TICK_LAST);
  assign shift_ext = {maj, shift_q};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      p_data_q     <= '0;
    end else begin
      sync1_q      <= RX_IN;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_bad_q    <= par_bad_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      p_data_q     <= p_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = at_wrap ? '0 : tick_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    s0_d      = (tick_q == TICK_S0) ? rx_s : s0_q;
    s1_d      = (tick_q == TICK_S1) ? rx_s : s1_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        // The cycle that first sees the low line is tick 0 of the start bit.
        if (!rx_s) begin
          state_d = START;
          tick_d  = TW'(1);
        end
      end
      START: begin
        if (at_dec) begin
          if (maj) begin
            state_d = IDLE;
            tick_d  = '0;
          end else begin
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            par_bad_d = 1'b0;
            bit_cnt_d = '0;
          end
        end else if (at_wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_dec) shift_d = shift_ext[DATA_WIDTH:1];
        if (at_wrap) begin
          if (bit_cnt_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
          else                       bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (at_dec)  par_bad_d = maj ^ (^shift_q) ^ par_typ_q;
        if (at_wrap) state_d   = STOP;
      end
      STOP: begin
        // Leaving half a bit early lets a back-to-back start edge be caught on time.
        if (at_dec) begin
          state_d = IDLE;
          tick_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY         = (state_q != IDLE);
    data_valid_d = (state_q == STOP) && at_dec && maj && !par_bad_q;
    par_err_d    = (state_q == STOP) && at_dec && par_bad_q;
    stp_err_d    = (state_q == STOP) && at_dec && !maj;
    p_data_d     = data_valid_d ? shift_q : p_data_q;
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed plus randomized frames for uart_rx_core, checked against a frame-level model
// of expected pulses, received words and start-to-valid latency.
module tb_uart_rx_core;

  localparam int DW   = 8;
  localparam int OS   = 8;
  localparam int HALF = OS / 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;
  logic          BUSY;

  int testsRun = 0;
  int failCount = 0;
  int cyc = 0;
  int validCnt = 0, parErrCnt = 0, stpErrCnt = 0, clashCnt = 0, lastValidCyc = 0;
  int expValidTot = 0, expPeTot = 0, expSeTot = 0;
  int frameStartCyc = 0;
  bit lastFrameValid = 1'b0;
  bit lastParEn = 1'b0;
  bit sawBusy;
  logic [DW-1:0] expPData;
  logic [DW-1:0] dataQ[$];
  logic [DW-1:0] expQ[$];
  logic [DW-1:0] rData;
  logic rPe, rPt, rPb, rSb;

  uart_rx_core #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor: counts every output pulse cycle and records words delivered.
  always @(negedge CLK) begin
    if (!RST) begin
      if (DATA_VALID) begin
        validCnt++;
        lastValidCyc = cyc;
        dataQ.push_back(P_DATA);
      end
      if (PAR_ERR) parErrCnt++;
      if (STP_ERR) stpErrCnt++;
      if (DATA_VALID && (PAR_ERR || STP_ERR)) clashCnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic driveBit(input logic b, input int glitchAt);
    for (int t = 0; t < OS; t++) begin
      RX_IN = (t == glitchAt) ? ~b : b;
      @(negedge CLK);
    end
  endtask

  task automatic idleLine(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // One serial frame plus its expected outcome from the parity/stop rules.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic parEn, input logic parTyp,
                               input logic parBit, input logic stopBit, input int glitchBit);
    logic pe, se;
    PAR_EN  = parEn;
    PAR_TYP = parTyp;
    frameStartCyc = cyc;
    driveBit(1'b0, -1);
    PAR_EN  = 1'($urandom);
    PAR_TYP = 1'($urandom);
    for (int i = 0; i < DW; i++) driveBit(data[i], (i == glitchBit) ? HALF : -1);
    if (parEn) driveBit(parBit, -1);
    driveBit(stopBit, -1);
    pe = parEn && (parBit != (parTyp ? ~(^data) : ^data));
    se = !stopBit;
    if (pe) expPeTot++;
    if (se) expSeTot++;
    lastParEn = parEn;
    lastFrameValid = !pe && !se;
    if (lastFrameValid) begin
      expValidTot++;
      expPData = data;
      expQ.push_back(data);
    end
  endtask

  task automatic checkpoint(input string tag);
    int bound;
    idleLine(2 * OS);
    checkOutput({tag, ":validCount"}, validCnt, expValidTot);
    checkOutput({tag, ":parErrCount"}, parErrCnt, expPeTot);
    checkOutput({tag, ":stpErrCount"}, stpErrCnt, expSeTot);
    checkOutput({tag, ":validWithErr"}, clashCnt, 0);
    checkOutput({tag, ":P_DATA"}, P_DATA, expPData);
    checkOutput({tag, ":BUSY"}, BUSY, 0);
    while (expQ.size() > 0) begin
      if (dataQ.size() == 0) begin
        checkOutput({tag, ":wordMissing"}, 0, 1);
        expQ.delete();
      end else begin
        checkOutput({tag, ":word"}, dataQ.pop_front(), expQ.pop_front());
      end
    end
    checkOutput({tag, ":extraWords"}, dataQ.size(), 0);
    dataQ.delete();
    if (lastFrameValid) begin
      bound = 2 + (1 + DW + int'(lastParEn)) * OS + HALF + 3;
      checkOutput({tag, ":latency"}, (lastValidCyc - frameStartCyc) <= bound, 1);
    end
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; expPData = '0;
    repeat (3) @(negedge CLK);
    checkOutput("rst:P_DATA", P_DATA, 0);
    checkOutput("rst:DATA_VALID", DATA_VALID, 0);
    checkOutput("rst:PAR_ERR", PAR_ERR, 0);
    checkOutput("rst:STP_ERR", STP_ERR, 0);
    checkOutput("rst:BUSY", BUSY, 0);
    RST = 1'b0;
    idleLine(OS);
    checkOutput("idle:BUSY", BUSY, 0);

    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    checkpoint("A5");
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    checkpoint("3C_even");
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    checkpoint("3C_parErr");
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    checkpoint("55_stopErr");
    applyStimulus(8'h96, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    checkpoint("96_bothErr");

    // Start-bit glitch: three low cycles must be rejected without any pulse.
    lastFrameValid = 1'b0;
    sawBusy = 1'b0;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (2 * OS) begin
      @(negedge CLK);
      if (BUSY) sawBusy = 1'b1;
    end
    checkOutput("startGlitch:busySeen", sawBusy, 1);
    checkpoint("startGlitch");
    applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    checkpoint("0F_dataGlitch");

    applyStimulus(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    checkpoint("backToBack");

    // Reset in the middle of data bit 3 aborts the frame.
    rData = 8'h5A;
    PAR_EN = 1'b0;
    driveBit(1'b0, -1);
    for (int i = 0; i < 3; i++) driveBit(rData[i], -1);
    RX_IN = rData[3];
    repeat (HALF) @(negedge CLK);
    checkOutput("midRst:busyBefore", BUSY, 1);
    #2 RST = 1'b1;
    #1;
    checkOutput("midRst:P_DATA", P_DATA, 0);
    checkOutput("midRst:BUSY", BUSY, 0);
    checkOutput("midRst:DATA_VALID", DATA_VALID, 0);
    checkOutput("midRst:PAR_ERR", PAR_ERR, 0);
    checkOutput("midRst:STP_ERR", STP_ERR, 0);
    RX_IN = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    expPData = '0;
    lastFrameValid = 1'b0;
    idleLine(OS);
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    checkpoint("81_afterRst");

    // Line stuck low: two full attempts end in stop errors, the third dies as a start glitch.
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (2 * ((1 + DW) * OS + HALF + 2) + 2) @(negedge CLK);
    expSeTot += 2;
    lastFrameValid = 1'b0;
    checkpoint("heldLow");
    applyStimulus(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    checkpoint("C3_odd");

    for (int n = 0; n < 16; n++) begin
      rData = DW'($urandom);
      rPe = 1'($urandom);
      rPt = 1'($urandom);
      rPb = (($urandom % 4) != 0) ? (rPt ? ~(^rData) : ^rData) : (rPt ? ^rData : ~(^rData));
      rSb = (($urandom % 5) != 0);
      applyStimulus(rData, rPe, rPt, rPb, rSb, (($urandom % 3) == 0) ? int'($urandom % DW) : -1);
      checkpoint($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
